// File: rtl/bcd_event_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_event_counter_if
// Brief    : Event/control inputs and count/display outputs of the BCD counter.
// Revision : 1.0
// ============================================================================
interface bcd_event_counter_if #(
    parameter int DIGITS = 3
);
    logic                  fire;
    logic                  enable;
    logic                  error;
    logic                  dir;
    logic                  clear;
    logic [4*DIGITS-1:0]   value;
    logic                  overflow;
    logic                  count_pulse;
    logic [DIGITS-1:0]     anode;
    logic [6:0]            segs;

    modport master (
        output fire, enable, error, dir, clear,
        input  value, overflow, count_pulse, anode, segs
    );

    modport slave (
        input  fire, enable, error, dir, clear,
        output value, overflow, count_pulse, anode, segs
    );
endinterface
`default_nettype wire

// File: rtl/bcd_event_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_event_counter
// Brief    : Synchronised event counter in BCD with wrap/saturate terminal
//            handling and a multiplexed seven-segment display driver.
// Revision : 1.0
// ============================================================================
module bcd_event_counter #(
    parameter int DIGITS   = 3,
    parameter int WRAP     = 1,
    parameter int SCAN_DIV = 100000
) (
    input  wire logic            clk,
    input  wire logic            reset,
    bcd_event_counter_if.slave   bus
);

    localparam int c_IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_PRESC_W = $clog2(SCAN_DIV);
    localparam logic [DIGITS-1:0]    c_ANODE_RST = ~DIGITS'(1);
    localparam logic [c_IDX_W-1:0]   c_IDX_LAST  = c_IDX_W'(DIGITS - 1);
    localparam logic [c_PRESC_W-1:0] c_PRESC_TC  = c_PRESC_W'(SCAN_DIV - 1);

    // ------------------------------------------------------------------
    // fire synchroniser and edge detect
    // ------------------------------------------------------------------
    logic       r_sync1;
    logic       r_sync2;
    logic       r_sync3;
    logic [1:0] r_prime;
    logic       r_armed;
    logic       w_edge;
    logic       w_accept;

    // r_prime marks when r_sync2 holds a genuine sample of fire; events are
    // only armed once fire has really been seen low after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_prime <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_sync1 <= bus.fire;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_prime <= {r_prime[0], 1'b1};
            if (r_prime[1] && !r_sync2)
                r_armed <= 1'b1;
        end
    end

    assign w_edge   = r_sync2 & ~r_sync3 & r_armed;
    assign w_accept = w_edge & bus.enable & ~bus.error & ~bus.clear;

    // ------------------------------------------------------------------
    // BCD next-value arithmetic
    // ------------------------------------------------------------------
    logic [4*DIGITS-1:0] r_value;
    logic [4*DIGITS-1:0] w_up;
    logic [4*DIGITS-1:0] w_down;
    logic [4*DIGITS-1:0] w_next;
    logic                w_all9;
    logic                w_all0;
    logic                w_term;
    logic                r_overflow;
    logic                r_pulse;

    always_comb begin : p_bcd_arith
        logic carry;
        logic borrow;
        w_up   = r_value;
        w_down = r_value;
        carry  = 1'b1;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (r_value[4*i +: 4] == 4'd9) begin
                    w_up[4*i +: 4] = 4'd0;
                end else begin
                    w_up[4*i +: 4] = r_value[4*i +: 4] + 4'd1;
                    carry          = 1'b0;
                end
            end
            if (borrow) begin
                if (r_value[4*i +: 4] == 4'd0) begin
                    w_down[4*i +: 4] = 4'd9;
                end else begin
                    w_down[4*i +: 4] = r_value[4*i +: 4] - 4'd1;
                    borrow           = 1'b0;
                end
            end
        end
        // A carry/borrow surviving every digit means the count was terminal.
        w_all9 = carry;
        w_all0 = borrow;
    end

    assign w_term = bus.dir ? w_all9 : w_all0;

    always_comb begin
        w_next = bus.dir ? w_up : w_down;
        if (w_term && (WRAP == 0))
            w_next = r_value;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_value    <= '0;
            r_overflow <= 1'b0;
            r_pulse    <= 1'b0;
        end else if (bus.clear) begin
            r_value    <= '0;
            r_overflow <= 1'b0;
            r_pulse    <= 1'b0;
        end else begin
            r_pulse <= w_accept;
            if (w_accept) begin
                r_value <= w_next;
                if (w_term)
                    r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    logic [c_PRESC_W-1:0] r_presc;
    logic [c_IDX_W-1:0]   r_idx;
    logic [DIGITS-1:0]    r_anode;
    logic [6:0]           r_segs;
    logic [DIGITS-1:0]    w_anode;
    logic [DIGITS-1:0]    w_blank;
    logic [3:0]           w_digit;
    logic [6:0]           w_segs;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (r_presc == c_PRESC_TC) begin
            r_presc <= '0;
            r_idx   <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);
        end else begin
            r_presc <= r_presc + c_PRESC_W'(1);
        end
    end

    // w_blank[i] is set when digit i and every more-significant digit are zero.
    always_comb begin : p_blank
        logic zero_above;
        zero_above = 1'b1;
        w_blank    = '0;
        w_anode    = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (r_value[4*i +: 4] == 4'd0);
            w_blank[i] = zero_above;
            w_anode[i] = (r_idx != c_IDX_W'(i));
        end
    end

    assign w_digit = r_value[{r_idx, 2'b00} +: 4];
    assign w_segs  = ((r_idx != '0) && w_blank[r_idx]) ? 7'b1111111 : seg_decode(w_digit);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_anode <= c_ANODE_RST;
            r_segs  <= 7'b1000000;
        end else begin
            r_anode <= w_anode;
            r_segs  <= w_segs;
        end
    end

    assign bus.value       = r_value;
    assign bus.overflow    = r_overflow;
    assign bus.count_pulse = r_pulse;
    assign bus.anode       = r_anode;
    assign bus.segs        = r_segs;

endmodule
`default_nettype wire

// File: tb/tb_bcd_event_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_event_counter
// Brief    : Directed self-checking bench; a wrapping and a saturating
//            instance share the same stimulus.
// Revision : 1.0
// ============================================================================
module tb_bcd_event_counter;

    logic clk;
    logic reset;
    logic fire, enable, error, dir, clear;

    int checks;
    int errors;
    int npw;
    int nps;
    int base_w;
    int base_s;

    bcd_event_counter_if #(.DIGITS(3)) bw ();
    bcd_event_counter_if #(.DIGITS(3)) bs ();

    assign bw.fire = fire;  assign bs.fire = fire;
    assign bw.enable = enable;  assign bs.enable = enable;
    assign bw.error = error;  assign bs.error = error;
    assign bw.dir = dir;  assign bs.dir = dir;
    assign bw.clear = clear;  assign bs.clear = clear;

    bcd_event_counter #(.DIGITS(3), .WRAP(1), .SCAN_DIV(4)) dut_w (
        .clk   (clk),
        .reset (reset),
        .bus   (bw.slave)
    );

    bcd_event_counter #(.DIGITS(3), .WRAP(0), .SCAN_DIV(4)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bs.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        npw = 0;
        nps = 0;
    end
    always @(negedge clk) begin
        if (bw.count_pulse === 1'b1) npw++;
        if (bs.count_pulse === 1'b1) nps++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulses(input int n);
        for (int k = 0; k < n; k++) begin
            fire = 1'b1;
            repeat (3) @(negedge clk);
            fire = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        fire = 1'b0; enable = 1'b1; error = 1'b0; dir = 1'b1; clear = 1'b0;

        // asynchronous reset, observed before any clock edge
        #2 reset = 1'b0;
        #1;
        chk("rst_value",  32'(bw.value), 32'h000);
        chk("rst_ovf",    32'(bw.overflow), 32'd0);
        chk("rst_pulse",  32'(bw.count_pulse), 32'd0);
        chk("rst_anode",  32'(bw.anode), 32'b110);
        chk("rst_segs",   32'(bw.segs), 32'b1000000);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // latency: update on the third edge after fire is first sampled
        fire = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("lat_before", 32'(bw.value), 32'h000);
        @(negedge clk);
        chk("lat_value",  32'(bw.value), 32'h001);
        chk("lat_pulse",  32'(bw.count_pulse), 32'd1);
        fire = 1'b0;
        @(negedge clk);
        chk("lat_pulse_lo", 32'(bw.count_pulse), 32'd0);
        repeat (2) @(negedge clk);

        pulses(11);
        chk("up12_value", 32'(bw.value), 32'h012);
        chk("up12_npulse", 32'(npw), 32'd12);
        chk("up12_ovf",   32'(bw.overflow), 32'd0);

        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_value", 32'(bw.value), 32'h000);

        // down from zero: wrap vs saturate
        dir = 1'b0;
        base_s = nps;
        pulses(1);
        chk("wdn_value", 32'(bw.value), 32'h999);
        chk("wdn_ovf",   32'(bw.overflow), 32'd1);
        chk("sdn_value", 32'(bs.value), 32'h000);
        chk("sdn_ovf",   32'(bs.overflow), 32'd1);
        chk("sdn_npulse", 32'(nps - base_s), 32'd1);

        dir = 1'b1;
        pulses(1);
        chk("wup_value", 32'(bw.value), 32'h000);
        chk("wup_ovf",   32'(bw.overflow), 32'd1);
        chk("sup_value", 32'(bs.value), 32'h001);

        // inhibited events
        base_w = npw;
        error = 1'b1;
        pulses(5);
        error = 1'b0;
        chk("err_value",  32'(bw.value), 32'h000);
        chk("err_npulse", 32'(npw - base_w), 32'd0);
        enable = 1'b0;
        pulses(3);
        enable = 1'b1;
        chk("dis_value",  32'(bs.value), 32'h001);
        chk("dis_npulse", 32'(npw - base_w), 32'd0);

        // clear coincident with the accepting edge
        fire = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clrev_value", 32'(bs.value), 32'h000);
        chk("clrev_ovf",   32'(bw.overflow), 32'd0);
        chk("clrev_pulse", 32'(bw.count_pulse), 32'd0);
        fire = 1'b0;
        repeat (3) @(negedge clk);
        chk("clrev_after", 32'(bw.value), 32'h000);

        // display scan on 0x047
        pulses(47);
        chk("d47_value", 32'(bw.value), 32'h047);
        for (int k = 0; k < 20 && bw.anode !== 3'b110; k++) @(negedge clk);
        for (int k = 0; k < 20 && bw.anode !== 3'b101; k++) @(negedge clk);
        chk("scan_sync", 32'(bw.anode), 32'b101);
        for (int k = 0; k < 12; k++) begin
            if (k < 4) begin
                chk("scan_an1", 32'(bw.anode), 32'b101);
                chk("scan_sg1", 32'(bw.segs), 32'b0011001);
            end else if (k < 8) begin
                chk("scan_an2", 32'(bw.anode), 32'b011);
                chk("scan_sg2", 32'(bw.segs), 32'b1111111);
            end else begin
                chk("scan_an0", 32'(bw.anode), 32'b110);
                chk("scan_sg0", 32'(bw.segs), 32'b1111000);
            end
            @(negedge clk);
        end

        // reset between edges while fire is high, fire held through release
        fire = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("mrst_value", 32'(bw.value), 32'h000);
        chk("mrst_anode", 32'(bw.anode), 32'b110);
        chk("mrst_segs",  32'(bw.segs), 32'b1000000);
        chk("mrst_pulse", 32'(bw.count_pulse), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        base_w = npw;
        repeat (10) @(negedge clk);
        chk("hold_value",  32'(bw.value), 32'h000);
        chk("hold_npulse", 32'(npw - base_w), 32'd0);
        fire = 1'b0;
        repeat (4) @(negedge clk);
        pulses(1);
        chk("rearm_value", 32'(bw.value), 32'h001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
